// File: rtl/id_stage.sv
// RV32I decode stage: decode, immediate generation, 32x32 register file, load-use hazard, ID/EX register.
// Optional ID_STAGE_WB_BYPASS_EN: write-through register file reads instead of a writeback stall.
module id_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] i_if_pc,
  input  logic [31:0]     i_if_instr,
  input  logic            i_if_valid,
  input  logic            i_flush,
  input  logic            i_wb_we,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_stall,
  output logic            o_id_valid,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_instr,
  output logic [XLEN-1:0] o_id_rs1_data,
  output logic [XLEN-1:0] o_id_rs2_data,
  output logic [XLEN-1:0] o_id_imm,
  output logic [4:0]      o_id_rs1,
  output logic [4:0]      o_id_rs2,
  output logic [4:0]      o_id_rd,
  output logic [2:0]      o_id_funct3,
  output logic [3:0]      o_id_alu_op,
  output logic            o_id_alu_a_pc,
  output logic            o_id_alu_b_imm,
  output logic            o_id_mem_read,
  output logic            o_id_mem_write,
  output logic            o_id_reg_write,
  output logic            o_id_branch,
  output logic            o_id_jump,
  output logic            o_id_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [3:0] AluAdd   = 4'd0;
  localparam logic [3:0] AluSub   = 4'd1;
  localparam logic [3:0] AluSll   = 4'd2;
  localparam logic [3:0] AluSlt   = 4'd3;
  localparam logic [3:0] AluSltu  = 4'd4;
  localparam logic [3:0] AluXor   = 4'd5;
  localparam logic [3:0] AluSrl   = 4'd6;
  localparam logic [3:0] AluSra   = 4'd7;
  localparam logic [3:0] AluOr    = 4'd8;
  localparam logic [3:0] AluAnd   = 4'd9;
  localparam logic [3:0] AluPassB = 4'd10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            alu_a_pc;
    logic            alu_b_imm;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } id_ex_t;

  // alt selects SUB (register ops only) or SRA, taken from instr[30].
  function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'd0:    alu_sel = (is_reg && alt) ? AluSub : AluAdd;
      3'd1:    alu_sel = AluSll;
      3'd2:    alu_sel = AluSlt;
      3'd3:    alu_sel = AluSltu;
      3'd4:    alu_sel = AluXor;
      3'd5:    alu_sel = alt ? AluSra : AluSrl;
      3'd6:    alu_sel = AluOr;
      default: alu_sel = AluAnd;
    endcase
  endfunction

  logic [XLEN-1:0] regs_q [32];
  id_ex_t          entry_q, entry_d, dec, bubble;
  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic            use_rs1, use_rs2;
  logic [XLEN-1:0] rs1_rdata, rs2_rdata;
  logic            wb_write, load_use, wb_hazard;

  assign opcode  = i_if_instr[6:0];
  assign rs1_idx = i_if_instr[19:15];
  assign rs2_idx = i_if_instr[24:20];

  assign imm_i = {{20{i_if_instr[31]}}, i_if_instr[31:20]};
  assign imm_s = {{20{i_if_instr[31]}}, i_if_instr[31:25], i_if_instr[11:7]};
  assign imm_b = {{19{i_if_instr[31]}}, i_if_instr[31], i_if_instr[7], i_if_instr[30:25],
                  i_if_instr[11:8], 1'b0};
  assign imm_u = {i_if_instr[31:12], 12'b0};
  assign imm_j = {{11{i_if_instr[31]}}, i_if_instr[31], i_if_instr[19:12], i_if_instr[20],
                  i_if_instr[30:21], 1'b0};

  assign wb_write = i_wb_we && (i_wb_rd != 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wb_write) begin
      regs_q[i_wb_rd] <= i_wb_data;
    end
  end

  always_comb begin
    rs1_rdata = regs_q[rs1_idx];
    rs2_rdata = regs_q[rs2_idx];
`ifdef ID_STAGE_WB_BYPASS_EN
    if (wb_write && (i_wb_rd == rs1_idx)) rs1_rdata = i_wb_data;
    if (wb_write && (i_wb_rd == rs2_idx)) rs2_rdata = i_wb_data;
`endif
    if (rs1_idx == 5'd0) rs1_rdata = '0;
    if (rs2_idx == 5'd0) rs2_rdata = '0;
  end

  always_comb begin
    dec          = '0;
    dec.valid    = 1'b1;
    dec.pc       = i_if_pc;
    dec.instr    = i_if_instr;
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = i_if_instr[11:7];
    dec.funct3   = i_if_instr[14:12];
    imm32        = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (opcode)
      OpLui: begin
        imm32 = imm_u; dec.alu_op = AluPassB; dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1;
      end
      OpAuipc: begin
        imm32 = imm_u; dec.alu_op = AluAdd; dec.alu_a_pc = 1'b1; dec.alu_b_imm = 1'b1;
        dec.reg_write = 1'b1;
      end
      OpJal: begin
        imm32 = imm_j; dec.alu_op = AluAdd; dec.alu_a_pc = 1'b1; dec.alu_b_imm = 1'b1;
        dec.reg_write = 1'b1; dec.jump = 1'b1;
      end
      OpJalr: begin
        imm32 = imm_i; dec.alu_op = AluAdd; dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1;
        dec.jump = 1'b1; use_rs1 = 1'b1;
      end
      OpBranch: begin
        imm32 = imm_b; dec.alu_op = AluSub; dec.branch = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OpLoad: begin
        imm32 = imm_i; dec.alu_op = AluAdd; dec.alu_b_imm = 1'b1; dec.mem_read = 1'b1;
        dec.reg_write = 1'b1; use_rs1 = 1'b1;
      end
      OpStore: begin
        imm32 = imm_s; dec.alu_op = AluAdd; dec.alu_b_imm = 1'b1; dec.mem_write = 1'b1;
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OpImm: begin
        imm32 = imm_i; dec.alu_op = alu_sel(i_if_instr[14:12], i_if_instr[30], 1'b0);
        dec.alu_b_imm = 1'b1; dec.reg_write = 1'b1; use_rs1 = 1'b1;
      end
      OpReg: begin
        dec.alu_op = alu_sel(i_if_instr[14:12], i_if_instr[30], 1'b1);
        dec.reg_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'($signed(imm32));
  end

  assign load_use = i_if_valid && entry_q.valid && entry_q.mem_read && (entry_q.rd != 5'd0) &&
                    ((use_rs1 && (entry_q.rd == rs1_idx)) || (use_rs2 && (entry_q.rd == rs2_idx)));

`ifdef ID_STAGE_WB_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  // Reads see the old value during a write, so wait one cycle and re-read.
  assign wb_hazard = i_if_valid && wb_write &&
                     ((use_rs1 && (i_wb_rd == rs1_idx)) || (use_rs2 && (i_wb_rd == rs2_idx)));
`endif

  assign o_stall = (load_use || wb_hazard) && !i_flush && !i_rst;

  always_comb begin
    bubble       = '0;
    bubble.instr = NOP_INSTR;
    entry_d      = bubble;
    if (i_if_valid && !i_flush && !o_stall) entry_d = dec;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) entry_q <= bubble;
    else       entry_q <= entry_d;
  end

  assign o_id_valid     = entry_q.valid;
  assign o_id_pc        = entry_q.pc;
  assign o_id_instr     = entry_q.instr;
  assign o_id_rs1_data  = entry_q.rs1_data;
  assign o_id_rs2_data  = entry_q.rs2_data;
  assign o_id_imm       = entry_q.imm;
  assign o_id_rs1       = entry_q.rs1;
  assign o_id_rs2       = entry_q.rs2;
  assign o_id_rd        = entry_q.rd;
  assign o_id_funct3    = entry_q.funct3;
  assign o_id_alu_op    = entry_q.alu_op;
  assign o_id_alu_a_pc  = entry_q.alu_a_pc;
  assign o_id_alu_b_imm = entry_q.alu_b_imm;
  assign o_id_mem_read  = entry_q.mem_read;
  assign o_id_mem_write = entry_q.mem_write;
  assign o_id_reg_write = entry_q.reg_write;
  assign o_id_branch    = entry_q.branch;
  assign o_id_jump      = entry_q.jump;
  assign o_id_illegal   = entry_q.illegal;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage of the 5-stage RV32I pipeline. It sits directly downstream of `if_stage` and consumes its `o_if_pc` / `o_if_instr` / `o_if_valid` outputs. It decodes the instruction, generates the immediate and reads the 32x32 register file. It also detects load-use hazards and registers the result into the ID/EX pipeline register for the execute stage.

## Interface
- `XLEN`, 32, datapath width
- `NOP_INSTR`, 32'h0000_0013, encoding reported in `o_id_instr` for bubbles
- `i_clk` in 1: core clock, rising edge
- `i_rst` in 1: synchronous, active-high reset
- `i_if_pc` in XLEN: PC of the fetched instruction
- `i_if_instr` in 32: fetched instruction
- `i_if_valid` in 1: fetch output is valid
- `i_flush` in 1: branch/jump taken in EX; kill the instruction in decode
- `i_wb_we` in 1: writeback enable
- `i_wb_rd` in 5: writeback destination register
- `i_wb_data` in XLEN: writeback data
- `o_stall` out 1: combinational; IF holds its PC and outputs this cycle
- `o_id_valid` out 1: ID/EX entry valid
- `o_id_pc` out XLEN: PC of the entry
- `o_id_instr` out 32: raw instruction (`NOP_INSTR` for bubbles)
- `o_id_rs1_data`, `o_id_rs2_data` out XLEN: operands
- `o_id_imm` out XLEN: sign-extended immediate
- `o_id_rs1`, `o_id_rs2`, `o_id_rd` out 5 each: register indices (for forwarding)
- `o_id_funct3` out 3: funct3 field
- `o_id_alu_op` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB
- `o_id_alu_a_pc` out 1: ALU operand A is the PC (AUIPC, JAL)
- `o_id_alu_b_imm` out 1: ALU operand B is the immediate
- `o_id_mem_read`, `o_id_mem_write`, `o_id_reg_write`, `o_id_branch`, `o_id_jump` out 1 each: control signals
- `o_id_illegal` out 1: unsupported opcode

## Operation
**Decode**
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediate formats: I, S, B, U, J.
- Any other opcode sets `o_id_illegal`=1 and `o_id_valid`=1; all write and memory controls are 0.
- Source usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
- ALU op mapping:
  - LUI → PASSB.
  - AUIPC, JAL, JALR, LOAD and STORE → ADD.
  - OP with funct7[5]=1 → SUB for funct3 0, SRA for funct3 5.
  - OP-IMM funct3=5 with imm[10]=1 → SRA.

**Register file**
- 31 writable registers; x0 always reads 0.
- A write occurs on the clock edge when `i_wb_we` is set and `i_wb_rd`≠0.
- All registers clear on reset.
- Reads are combinational.

**Hazard (load-use)**
- `o_stall`=1 when all of the following hold:
  - `i_if_valid`, `o_id_valid` and `o_id_mem_read` are set;
  - `o_id_rd`≠0;
  - `o_id_rd` equals a source register that the decoded instruction actually uses.
- While stalled, a bubble is loaded into ID/EX: `o_id_valid`=0, all controls 0, `o_id_instr`=`NOP_INSTR`. The instruction stays at the input.

**Priority on each clock edge:** `i_rst` > `i_flush` > stall > normal load.
- On `i_flush`: ID/EX loads a bubble and `o_stall` is forced to 0.
- When `i_if_valid`=0: ID/EX loads a bubble.

## Timing
- Latency is 1 cycle: an instruction present at the input edge N appears on the `o_id_*` outputs after edge N.
- A load-use stall lasts exactly 1 cycle, because the bubble clears the hazard condition on the next cycle.
- Reset values:
  - every `o_id_*` output is 0, except `o_id_instr`=`NOP_INSTR`;
  - `o_stall`=0 while `i_rst`=1;
  - the register file is all zeros.
- Reset asserted mid-stall: bubble and cleared state on the next edge; the stall is dropped.
- Flush and stall asserted in the same cycle: flush wins, and `o_stall` is 0.
- A write to x0 is ignored; reading x0 during that write still returns 0.

## Configuration
- `ID_STAGE_WB_BYPASS_EN` defined:
  - a read of register r in the same cycle as a write to r (r≠0) returns `i_wb_data` (write-through);
  - no extra stall.
- Not defined:
  - the read returns the old value;
  - the hazard logic additionally asserts `o_stall` for 1 cycle when `i_wb_we`, `i_wb_rd`≠0 and `i_wb_rd` equals a used source register;
  - the re-read after the stall returns the updated value.

## Test plan
- **Reset:** hold `i_rst`=1 for 2 cycles with a valid `addi x1,x0,1` at the input → all outputs at their reset values and `o_stall`=0. After release, `o_id_valid`=1, `o_id_imm`=1, `o_id_rd`=1, ALU op ADD, `o_id_alu_b_imm`=1.
- **Immediates:** apply `sw x2,8(x1)`, `beq x1,x2,-4`, `jal x1,0x10`, `lui x5,0x12345` → `o_id_imm` = 8, 0xFFFF_FFFC, 0x10 and 0x1234_5000 respectively, with the matching control signals.
- **Load-use:** `lw x3,0(x1)` followed by `add x4,x3,x2` → `o_stall`=1 for 1 cycle and one bubble in ID/EX, then the add issues. A following `lui x3,...` after `lw x3` does not stall.
- **Writeback:** `i_wb_we`=1, rd=7, data=0xDEAD_BEEF while decoding `add x8,x7,x0`:
  - with the macro: `o_id_rs1_data`=0xDEAD_BEEF and no stall;
  - without the macro: 1-cycle stall, then 0xDEAD_BEEF.
  - A write to x0 leaves x0 reading 0.
- **Flush priority:** `i_flush`=1 coinciding with a load-use hazard → `o_stall`=0 and a bubble on the next edge. Opcode 7'h7F → `o_id_illegal`=1, `o_id_reg_write`=0.
